// File: rtl/branch_predict_unit_if.sv
// Bundle between the pipeline and the branch unit: fetch-side lookup, execute-side
// resolve inputs, and the registered redirect/statistics outputs.
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  i_fetch_pc;
    logic             o_pred_taken;
    logic [XLEN-1:0]  o_pred_pc;

    logic             i_ex_valid;
    logic [XLEN-1:0]  i_ex_pc;
    logic [6:0]       i_opcode;
    logic [2:0]       i_func_3;
    logic [11:0]      i_imm_12_i;
    logic [19:0]      i_imm_20;
    logic [11:0]      i_imm_12_b;
    logic [XLEN-1:0]  i_rs_1;
    logic [XLEN-1:0]  i_rs_2;
    logic [XLEN-1:0]  i_pred_pc;

    logic             o_redirect_valid;
    logic [XLEN-1:0]  o_redirect_pc;
    logic [CNT_W-1:0] o_mispredict_count;

    modport master (
        output i_fetch_pc, i_ex_valid, i_ex_pc, i_opcode, i_func_3,
               i_imm_12_i, i_imm_20, i_imm_12_b, i_rs_1, i_rs_2, i_pred_pc,
        input  o_pred_taken, o_pred_pc, o_redirect_valid, o_redirect_pc,
               o_mispredict_count
    );

    modport slave (
        input  i_fetch_pc, i_ex_valid, i_ex_pc, i_opcode, i_func_3,
               i_imm_12_i, i_imm_20, i_imm_12_b, i_rs_1, i_rs_2, i_pred_pc,
        output o_pred_taken, o_pred_pc, o_redirect_valid, o_redirect_pc,
               o_mispredict_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch unit: BTB + 2-bit BHT lookup for fetch, JAL/JALR/BRANCH resolution in
// execute, registered redirect on mispredict, table training and mispredict count.
module branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int BTB_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    branch_predict_unit_if.slave  bus
);

    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = XLEN - BTB_IDX_W - 2;

    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    logic [1:0]       bht        [BHT_N];
    logic             btb_valid  [BTB_N];
    logic [TAG_W-1:0] btb_tag    [BTB_N];
    logic [XLEN-1:0]  btb_target [BTB_N];
    logic             btb_jump   [BTB_N];

    logic [XLEN-1:0]  redirect_pc_q;
    logic             redirect_valid_q;
    logic [CNT_W-1:0] mispredict_count_q;

    // ---------------- fetch-side lookup ----------------
    logic [BTB_IDX_W-1:0] f_btb_idx;
    logic [TAG_W-1:0]     f_tag;
    logic [BHT_IDX_W-1:0] f_bht_idx;
    logic                 f_hit;
    logic                 f_taken;

    assign f_btb_idx = bus.i_fetch_pc[BTB_IDX_W+1:2];
    assign f_tag     = bus.i_fetch_pc[XLEN-1:BTB_IDX_W+2];
    assign f_bht_idx = bus.i_fetch_pc[BHT_IDX_W+1:2];
    assign f_hit     = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
    assign f_taken   = f_hit && (btb_jump[f_btb_idx] || bht[f_bht_idx][1]);

    assign bus.o_pred_taken = f_taken;
    assign bus.o_pred_pc    = f_taken ? btb_target[f_btb_idx]
                                      : bus.i_fetch_pc + XLEN'(4);

    // ---------------- execute-side resolve ----------------
    logic [XLEN-1:0]      imm_i;
    logic [XLEN-1:0]      imm_j;
    logic [XLEN-1:0]      imm_b;
    logic [XLEN-1:0]      ex_pc_plus4;
    logic [XLEN-1:0]      target;
    logic [XLEN-1:0]      actual_next;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 is_branch;
    logic                 is_control;
    logic                 cond_true;
    logic                 taken;
    logic                 mispredict;
    logic [BTB_IDX_W-1:0] e_btb_idx;
    logic [TAG_W-1:0]     e_tag;
    logic [BHT_IDX_W-1:0] e_bht_idx;
    logic                 e_hit;

    assign imm_i = {{(XLEN-12){bus.i_imm_12_i[11]}}, bus.i_imm_12_i};
    assign imm_j = {{(XLEN-21){bus.i_imm_20[19]}}, bus.i_imm_20, 1'b0};
    assign imm_b = {{(XLEN-13){bus.i_imm_12_b[11]}}, bus.i_imm_12_b, 1'b0};

    assign ex_pc_plus4 = bus.i_ex_pc + XLEN'(4);
    assign is_jal      = (bus.i_opcode == JAL);
    assign is_jalr     = (bus.i_opcode == JALR);
    assign is_branch   = (bus.i_opcode == BRANCH);
    assign is_control  = is_jal || is_jalr || is_branch;

    assign e_btb_idx = bus.i_ex_pc[BTB_IDX_W+1:2];
    assign e_tag     = bus.i_ex_pc[XLEN-1:BTB_IDX_W+2];
    assign e_bht_idx = bus.i_ex_pc[BHT_IDX_W+1:2];
    assign e_hit     = btb_valid[e_btb_idx] && (btb_tag[e_btb_idx] == e_tag);

    // Branch condition; the two reserved funct3 encodings never take.
    always_comb begin
        cond_true = 1'b0;
        case (bus.i_func_3)
            BEQ:     cond_true = (bus.i_rs_1 == bus.i_rs_2);
            BNE:     cond_true = (bus.i_rs_1 != bus.i_rs_2);
            BLT:     cond_true = ($signed(bus.i_rs_1) <  $signed(bus.i_rs_2));
            BGE:     cond_true = ($signed(bus.i_rs_1) >= $signed(bus.i_rs_2));
            BLTU:    cond_true = (bus.i_rs_1 <  bus.i_rs_2);
            BGEU:    cond_true = (bus.i_rs_1 >= bus.i_rs_2);
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = bus.i_ex_pc + imm_b;
        if (is_jal) begin
            taken  = 1'b1;
            target = bus.i_ex_pc + imm_j;
        end else if (is_jalr) begin
            taken  = 1'b1;
            target = (bus.i_rs_1 + imm_i) & ~XLEN'(1);
        end else if (is_branch) begin
            taken  = cond_true;
            target = bus.i_ex_pc + imm_b;
        end
    end

    assign actual_next = taken ? target : ex_pc_plus4;
    assign mispredict  = bus.i_ex_valid && (actual_next != bus.i_pred_pc);

    // ---------------- redirect and statistics ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            mispredict_count_q <= '0;
        end else begin
            redirect_valid_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= actual_next;
                if (mispredict_count_q != {CNT_W{1'b1}})
                    mispredict_count_q <= mispredict_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.o_redirect_valid   = redirect_valid_q;
    assign bus.o_redirect_pc      = redirect_pc_q;
    assign bus.o_mispredict_count = mispredict_count_q;

    // ---------------- BHT training ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_N; i++)
                bht[i] <= 2'b01;
        end else if (bus.i_ex_valid && is_branch) begin
            if (taken && bht[e_bht_idx] != 2'b11)
                bht[e_bht_idx] <= bht[e_bht_idx] + 2'b01;
            else if (!taken && bht[e_bht_idx] != 2'b00)
                bht[e_bht_idx] <= bht[e_bht_idx] - 2'b01;
        end
    end

    // ---------------- BTB training ----------------
    // A non-control instruction that hits means a stale alias; drop the entry so
    // fetch stops jumping from that PC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_N; i++)
                btb_valid[i] <= 1'b0;
        end else if (bus.i_ex_valid && taken) begin
            btb_valid[e_btb_idx] <= 1'b1;
        end else if (bus.i_ex_valid && !is_control && e_hit) begin
            btb_valid[e_btb_idx] <= 1'b0;
        end
    end

    // Payload fields need no reset; they are qualified by btb_valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && bus.i_ex_valid && taken) begin
            btb_tag[e_btb_idx]    <= e_tag;
            btb_target[e_btb_idx] <= target;
            btb_jump[e_btb_idx]   <= is_jal || is_jalr;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: expected redirect state is queued when
// each cycle is driven and popped/compared one clock later; lookups are checked directly.
module tb_branch_predict_unit;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [15:0] count;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t        sb[$];
    logic [31:0] model_pc;
    logic [15:0] model_count;

    branch_predict_unit_if #(.XLEN(32), .CNT_W(16)) bus ();

    branch_predict_unit #(
        .XLEN(32), .BHT_IDX_W(6), .BTB_IDX_W(4), .CNT_W(16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock and compare the registered outputs with the oldest queued expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            total++;
            assert (bus.o_redirect_valid === e.valid) else begin
                bad++;
                $error("[TB] FAIL redirect_valid got=%0b exp=%0b", bus.o_redirect_valid, e.valid);
            end
            total++;
            assert (bus.o_redirect_pc === e.pc) else begin
                bad++;
                $error("[TB] FAIL redirect_pc got=%h exp=%h", bus.o_redirect_pc, e.pc);
            end
            total++;
            assert (bus.o_mispredict_count === e.count) else begin
                bad++;
                $error("[TB] FAIL mispredict_count got=%0d exp=%0d", bus.o_mispredict_count, e.count);
            end
        end
    endtask

    task automatic push_expect(input logic mis, input logic [31:0] pc);
        exp_t e;
        if (mis) begin
            model_pc = pc;
            if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
        end
        e.valid = mis;
        e.pc    = model_pc;
        e.count = model_count;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [31:0] pc,
        input logic [11:0] imm_i,
        input logic [19:0] imm_j,
        input logic [11:0] imm_b,
        input logic [31:0] rs1,
        input logic [31:0] rs2,
        input logic [31:0] pred,
        input logic        exp_mis,
        input logic [31:0] exp_pc
    );
        bus.i_ex_valid = 1'b1;
        bus.i_ex_pc    = pc;
        bus.i_opcode   = op;
        bus.i_func_3   = f3;
        bus.i_imm_12_i = imm_i;
        bus.i_imm_20   = imm_j;
        bus.i_imm_12_b = imm_b;
        bus.i_rs_1     = rs1;
        bus.i_rs_2     = rs2;
        bus.i_pred_pc  = pred;
        push_expect(exp_mis, exp_pc);
        tick();
    endtask

    task automatic idle_cycle();
        bus.i_ex_valid = 1'b0;
        push_expect(1'b0, 32'h0);
        tick();
    endtask

    task automatic reset_cycle();
        exp_t e;
        rst = 1'b1;
        model_pc    = 32'h0;
        model_count = 16'h0;
        e.valid = 1'b0;
        e.pc    = 32'h0;
        e.count = 16'h0;
        sb.push_back(e);
        tick();
        rst = 1'b0;
    endtask

    task automatic check_output(input logic [31:0] fpc, input logic exp_taken, input logic [31:0] exp_pc);
        bus.i_fetch_pc = fpc;
        #1;
        total++;
        assert (bus.o_pred_taken === exp_taken) else begin
            bad++;
            $error("[TB] FAIL pred_taken@%h got=%0b exp=%0b", fpc, bus.o_pred_taken, exp_taken);
        end
        total++;
        assert (bus.o_pred_pc === exp_pc) else begin
            bad++;
            $error("[TB] FAIL pred_pc@%h got=%h exp=%h", fpc, bus.o_pred_pc, exp_pc);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_pc    = 32'h0;
        model_count = 16'h0;
        rst = 1'b1;
        bus.i_fetch_pc = 32'h0;
        bus.i_ex_valid = 1'b0;
        bus.i_ex_pc    = 32'h0;
        bus.i_opcode   = 7'h0;
        bus.i_func_3   = 3'h0;
        bus.i_imm_12_i = 12'h0;
        bus.i_imm_20   = 20'h0;
        bus.i_imm_12_b = 12'h0;
        bus.i_rs_1     = 32'h0;
        bus.i_rs_2     = 32'h0;
        bus.i_pred_pc  = 32'h0;
        #2;

        $display("[TB] reset");
        reset_cycle();

        $display("[TB] JAL learn");
        check_output(32'h100, 1'b0, 32'h104);
        apply_stimulus(OP_JAL, 3'b000, 32'h100, 12'h0, 20'h00020, 12'h0, 32'h0, 32'h0, 32'h104, 1'b1, 32'h140);
        check_output(32'h100, 1'b1, 32'h140);
        idle_cycle();

        $display("[TB] BNE loop");
        check_output(32'h200, 1'b0, 32'h204);
        apply_stimulus(OP_BRANCH, 3'b001, 32'h200, 12'h0, 20'h0, 12'hFFC, 32'd1, 32'd2, 32'h204, 1'b1, 32'h1F8);
        check_output(32'h200, 1'b1, 32'h1F8);
        apply_stimulus(OP_BRANCH, 3'b001, 32'h200, 12'h0, 20'h0, 12'hFFC, 32'd1, 32'd2, 32'h1F8, 1'b0, 32'h0);
        apply_stimulus(OP_BRANCH, 3'b001, 32'h200, 12'h0, 20'h0, 12'hFFC, 32'd1, 32'd2, 32'h1F8, 1'b0, 32'h0);
        apply_stimulus(OP_BRANCH, 3'b001, 32'h200, 12'h0, 20'h0, 12'hFFC, 32'd5, 32'd5, 32'h1F8, 1'b1, 32'h204);
        check_output(32'h200, 1'b1, 32'h1F8);
        apply_stimulus(OP_BRANCH, 3'b001, 32'h200, 12'h0, 20'h0, 12'hFFC, 32'd5, 32'd5, 32'h1F8, 1'b1, 32'h204);
        check_output(32'h200, 1'b0, 32'h204);

        $display("[TB] JALR targets");
        apply_stimulus(OP_JALR, 3'b000, 32'h400, 12'hFFF, 20'h0, 12'h0, 32'h1001, 32'h0, 32'h404, 1'b1, 32'h1000);
        apply_stimulus(OP_JALR, 3'b000, 32'h404, 12'h002, 20'h0, 12'h0, 32'hFFFFFFFF, 32'h0, 32'h408, 1'b1, 32'h0);
        check_output(32'h400, 1'b1, 32'h1000);
        check_output(32'h404, 1'b1, 32'h0);

        $display("[TB] compare variants");
        apply_stimulus(OP_BRANCH, 3'b101, 32'h500, 12'h0, 20'h0, 12'h008, 32'h80000000, 32'h80000000, 32'h510, 1'b0, 32'h0);
        apply_stimulus(OP_BRANCH, 3'b111, 32'h504, 12'h0, 20'h0, 12'h008, 32'h80000000, 32'h80000000, 32'h514, 1'b0, 32'h0);
        apply_stimulus(OP_BRANCH, 3'b100, 32'h508, 12'h0, 20'h0, 12'h008, 32'hFFFFFFFF, 32'h1, 32'h50C, 1'b1, 32'h518);
        apply_stimulus(OP_BRANCH, 3'b110, 32'h50C, 12'h0, 20'h0, 12'h008, 32'hFFFFFFFF, 32'h1, 32'h51C, 1'b1, 32'h510);
        apply_stimulus(OP_BRANCH, 3'b010, 32'h600, 12'h0, 20'h0, 12'h008, 32'h0, 32'h0, 32'h604, 1'b0, 32'h0);
        idle_cycle();

        $display("[TB] alias clean-up");
        apply_stimulus(OP_JAL, 3'b000, 32'h300, 12'h0, 20'h00040, 12'h0, 32'h0, 32'h0, 32'h304, 1'b1, 32'h380);
        check_output(32'h300, 1'b1, 32'h380);
        apply_stimulus(OP_ADDI, 3'b000, 32'h300, 12'h001, 20'h0, 12'h0, 32'h0, 32'h0, 32'h380, 1'b1, 32'h304);
        check_output(32'h300, 1'b0, 32'h304);
        idle_cycle();

        $display("[TB] reset over mispredict");
        bus.i_ex_valid = 1'b1;
        bus.i_ex_pc    = 32'h700;
        bus.i_opcode   = OP_JAL;
        bus.i_imm_20   = 20'h00020;
        bus.i_pred_pc  = 32'h704;
        reset_cycle();
        bus.i_ex_valid = 1'b0;
        check_output(32'h400, 1'b0, 32'h404);
        check_output(32'h404, 1'b0, 32'h408);
        check_output(32'h700, 1'b0, 32'h704);
        idle_cycle();

        $display("[TB] BHT restart from weakly-not-taken");
        apply_stimulus(OP_BRANCH, 3'b000, 32'h200, 12'h0, 20'h0, 12'hFFC, 32'd3, 32'd3, 32'h204, 1'b1, 32'h1F8);
        check_output(32'h200, 1'b1, 32'h1F8);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
